// File: rtl/sarr_gen.sv
// -----------------------------------------------------------------------------
// sarr_gen -- state-array generator
//
// Holds a DEPTH x DATA_W array that refills itself with the identity pattern
// (mem[i] = i mod 2**DATA_W) after reset or on request. When the fill is done
// the array accepts single-cycle writes, atomic two-entry swaps and registered
// reads. Commands that arrive during a fill, or that lose on priority, are
// discarded and flagged on drop_o.
//
// Ports
//   clk        in   single clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   init_i     in   pulse: restart the identity fill from entry 0
//   wenable_i  in   write strobe, mem[waddr_i] <= wdata_i
//   waddr_i    in   write address / first swap address
//   wdata_i    in   write data
//   swap_i     in   swap strobe, exchanges mem[waddr_i] and mem[raddr_i]
//   renable_i  in   read strobe
//   raddr_i    in   read address / second swap address
//   rdata_o    out  registered read data, holds when no read
//   rvalid_o   out  one-cycle flag that rdata_o carries a fresh read
//   busy_o     out  high while the identity fill runs
//   drop_o     out  one-cycle pulse when a command was discarded
//
// Build option
//   SARR_RD_BYPASS_EN  when defined, a read that hits a same-cycle write or
//                      swap returns the updated value; otherwise it returns
//                      the value held before the update.
//
// FSM states
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_FILL  | writing mem[cnt] = cnt, one entry per cycle; commands dropped
//   ST_READY | array usable: write / swap / read accepted
// -----------------------------------------------------------------------------
module sarr_gen #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              init_i,
    input  logic              wenable_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              swap_i,
    input  logic              renable_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              busy_o,
    output logic              drop_o
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_busy;
    logic              r_drop;

    // Storage is deliberately left out of reset; the fill defines its contents.
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_in_fill;
    logic              w_do_fill;
    logic              w_do_write;
    logic              w_do_swap;
    logic              w_do_read;
    logic              w_drop;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [DATA_W-1:0] w_fill_data;
    logic [DATA_W-1:0] w_rd_data;

    // ------------------------------------------------------------------
    // Command decode: init > write > swap. Everything but init is dropped
    // while filling; a read in READY is always accepted alongside the rest.
    // ------------------------------------------------------------------
    assign w_in_fill  = (r_state == ST_FILL);
    assign w_do_fill  = w_in_fill && !init_i;
    assign w_do_write = !w_in_fill && !init_i && wenable_i;
    assign w_do_swap  = !w_in_fill && !init_i && !wenable_i && swap_i;
    assign w_do_read  = !w_in_fill && renable_i;

    always_comb begin
        w_drop = 1'b0;
        if (w_in_fill) begin
            w_drop = wenable_i || swap_i || renable_i;
        end else begin
            w_drop = (init_i && (wenable_i || swap_i)) || (wenable_i && swap_i);
        end
    end

    // The extra counter bit carries out exactly when entry DEPTH-1 is written.
    assign w_cnt_nxt = r_cnt + {{ADDR_W{1'b0}}, 1'b1};

    // Fill value is cnt mod 2**DATA_W: truncate or zero-extend the address.
    generate
        if (DATA_W <= ADDR_W) begin : g_fill_trunc
            assign w_fill_data = r_cnt[DATA_W-1:0];
        end else begin : g_fill_ext
            assign w_fill_data = {{(DATA_W-ADDR_W){1'b0}}, r_cnt[ADDR_W-1:0]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read data source
    // ------------------------------------------------------------------
`ifdef SARR_RD_BYPASS_EN
    // raddr_i is always one of the swap addresses, so after a swap it holds
    // what was at waddr_i.
    always_comb begin
        w_rd_data = r_mem[raddr_i];
        if (w_do_write && (waddr_i == raddr_i)) begin
            w_rd_data = wdata_i;
        end else if (w_do_swap) begin
            w_rd_data = r_mem[waddr_i];
        end
    end
`else
    assign w_rd_data = r_mem[raddr_i];
`endif

    // ------------------------------------------------------------------
    // Array update. Both swap writes read the old contents, so an equal
    // address pair rewrites the entry with its own value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_do_fill) begin
            r_mem[r_cnt[ADDR_W-1:0]] <= w_fill_data;
        end else if (w_do_write) begin
            r_mem[waddr_i] <= wdata_i;
        end else if (w_do_swap) begin
            r_mem[waddr_i] <= r_mem[raddr_i];
            r_mem[raddr_i] <= r_mem[waddr_i];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= ST_FILL;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_drop   <= w_drop;
            r_rvalid <= w_do_read;
            if (w_do_read) begin
                r_rdata <= w_rd_data;
            end

            case (r_state)
                ST_FILL: begin
                    if (init_i) begin
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end else if (w_cnt_nxt[ADDR_W]) begin
                        r_state <= ST_READY;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                ST_READY: begin
                    if (init_i) begin
                        r_state <= ST_FILL;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign rdata_o  = r_rdata;
    assign rvalid_o = r_rvalid;
    assign busy_o   = r_busy;
    assign drop_o   = r_drop;

endmodule

// File: tb/tb_sarr_gen.sv
module tb_sarr_gen;

    logic       clk;
    logic       n_rst;
    logic       init_i, wenable_i, swap_i, renable_i;
    logic [7:0] waddr_i, wdata_i, raddr_i;
    logic [7:0] rdata_o;
    logic       rvalid_o, busy_o, drop_o;

    // small instance: ADDR_W=4, DATA_W=3
    logic       s_init, s_we, s_sw, s_re;
    logic [3:0] s_wa, s_ra;
    logic [2:0] s_wd;
    logic [2:0] s_rdata;
    logic       s_rvalid, s_busy, s_drop;

    sarr_gen u_dut (
        .clk(clk), .n_rst(n_rst), .init_i(init_i), .wenable_i(wenable_i),
        .waddr_i(waddr_i), .wdata_i(wdata_i), .swap_i(swap_i),
        .renable_i(renable_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
        .rvalid_o(rvalid_o), .busy_o(busy_o), .drop_o(drop_o)
    );

    sarr_gen #(.DATA_W(3), .ADDR_W(4)) u_dut_s (
        .clk(clk), .n_rst(n_rst), .init_i(s_init), .wenable_i(s_we),
        .waddr_i(s_wa), .wdata_i(s_wd), .swap_i(s_sw),
        .renable_i(s_re), .raddr_i(s_ra), .rdata_o(s_rdata),
        .rvalid_o(s_rvalid), .busy_o(s_busy), .drop_o(s_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // reference model + scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] m_mem [256];
    bit         m_busy;

    task automatic model_identity();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'(i);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rvalid_o) begin
            if (sb_q.size() == 0) begin
                chk("rvalid_unexpected", 32'(rvalid_o), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rdata", 32'(rdata_o), 32'(e.d));
                chk("rd_latency", 32'(cyc), 32'(e.c));
            end
        end
    end

    // drives one command for one cycle, checks drop_o / rvalid_o afterwards
    task automatic cmd(input bit ini, input bit we, input bit sw, input bit re,
                       input logic [7:0] wa, input logic [7:0] wd, input logic [7:0] ra);
        bit         e_drop, acc_rd, do_w, do_s;
        logic [7:0] e_rd, tmp;
        exp_t       e;
        if (m_busy) begin
            e_drop = we | sw | re;
            acc_rd = 1'b0;
            do_w   = 1'b0;
            do_s   = 1'b0;
        end else begin
            e_drop = (ini & (we | sw)) | (we & sw);
            acc_rd = re;
            do_w   = !ini && we;
            do_s   = !ini && !we && sw;
        end
        e_rd = m_mem[ra];
`ifdef SARR_RD_BYPASS_EN
        if (do_w && (wa == ra)) e_rd = wd;
        else if (do_s)          e_rd = m_mem[wa];
`endif
        if (acc_rd) begin
            e.d = e_rd;
            e.c = cyc + 1;
            sb_q.push_back(e);
        end
        if (ini) begin
            model_identity();
            m_busy = 1'b1;
        end else if (do_w) begin
            m_mem[wa] = wd;
        end else if (do_s) begin
            tmp       = m_mem[wa];
            m_mem[wa] = m_mem[ra];
            m_mem[ra] = tmp;
        end
        init_i = ini; wenable_i = we; swap_i = sw; renable_i = re;
        waddr_i = wa; wdata_i = wd; raddr_i = ra;
        @(negedge clk);
        chk("drop", 32'(drop_o), 32'(e_drop));
        if (!acc_rd) chk("rvalid_low", 32'(rvalid_o), 32'd0);
        init_i = 1'b0; wenable_i = 1'b0; swap_i = 1'b0; renable_i = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, a);
    endtask

    // counts negedges with busy_o high, starting at the current negedge
    task automatic wait_fill(input int exp_len, input string tag);
        int n = 0;
        while (busy_o && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk(tag, 32'(n), 32'(exp_len));
        model_identity();
        m_busy = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, ns;
        n_rst = 1'b0;
        init_i = 0; wenable_i = 0; swap_i = 0; renable_i = 0;
        waddr_i = 0; wdata_i = 0; raddr_i = 0;
        s_init = 0; s_we = 0; s_sw = 0; s_re = 0; s_wa = 0; s_wd = 0; s_ra = 0;
        m_busy = 1'b1;
        model_identity();
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_rdata", 32'(rdata_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_drop", 32'(drop_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_busy_small", 32'(s_busy), 32'd1);

        // first fill: both instances measured together
        n_rst = 1'b1;
        nb = 0; ns = 0;
        while ((busy_o || s_busy) && nb < 2000) begin
            if (busy_o) nb++;
            if (s_busy) ns++;
            @(negedge clk);
        end
        chk("fill_len", 32'(nb), 32'd256);
        chk("fill_len_small", 32'(ns), 32'd16);
        m_busy = 1'b0;

        // small instance: 9 mod 8 = 1, 15 mod 8 = 7
        s_re = 1'b1; s_ra = 4'd9;
        @(negedge clk);
        chk("small_rvalid", 32'(s_rvalid), 32'd1);
        chk("small_rd9", 32'(s_rdata), 32'd1);
        s_ra = 4'd15;
        @(negedge clk);
        chk("small_rd15", 32'(s_rdata), 32'd7);
        s_re = 1'b0;
        @(negedge clk);
        chk("small_rvalid_low", 32'(s_rvalid), 32'd0);

        // identity reads
        rd(8'h00); rd(8'h07); rd(8'hFF);
        @(negedge clk);
        chk("rd_hold_data", 32'(rdata_o), 32'hFF);
        chk("rd_hold_valid", 32'(rvalid_o), 32'd0);

        // write then read
        cmd(0, 1, 0, 0, 8'h10, 8'hA5, 8'h00);
        rd(8'h10);
        // write + swap same cycle: swap dropped
        cmd(0, 1, 1, 0, 8'h11, 8'h5A, 8'h12);
        rd(8'h11); rd(8'h12);

        // swaps
        cmd(0, 0, 1, 0, 8'h03, 8'h00, 8'hFC);
        rd(8'h03); rd(8'hFC);
        cmd(0, 0, 1, 0, 8'h20, 8'h00, 8'h20);
        rd(8'h20);

        // read during update
        cmd(0, 1, 0, 1, 8'h40, 8'h99, 8'h40);
        rd(8'h40);
        cmd(0, 0, 1, 1, 8'h05, 8'h00, 8'h06);
        rd(8'h05); rd(8'h06);

        // random mix
        for (int i = 0; i < 60; i++) begin
            cmd(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 15)),
                8'($urandom), 8'($urandom_range(0, 15)));
        end
        for (int a = 0; a < 16; a++) rd(8'(a));

        // init restart, reads dropped while busy, reset mid-fill
        cmd(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("init_busy", 32'(busy_o), 32'd1);
        repeat (99) @(negedge clk);
        cmd(1, 0, 0, 1, 8'h00, 8'h00, 8'h10);
        repeat (20) @(negedge clk);
        rd(8'h01);
        cmd(0, 1, 0, 0, 8'h02, 8'h33, 8'h00);
        repeat (27) @(negedge clk);
        chk("fill_busy_mid", 32'(busy_o), 32'd1);
        n_rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy_o), 32'd1);
        chk("rst_mid_drop", 32'(drop_o), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        wait_fill(256, "refill_len");
        rd(8'h10); rd(8'h03); rd(8'h40); rd(8'h02); rd(8'hFC);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
